fft_stage4_butterfly: RTL and testbench
=======================================

# fft_stage4_butterfly

Registered radix-2 butterfly stage for the 32-point FFT. It consumes the permuted frame from the stage-3/stage-4 mapper and performs the 16 stage-4 butterflies on adjacent pairs. Four butterfly lanes are time-multiplexed over four cycles, and the block has valid/ready handshakes on both sides. The output feeds the next stage's mapper.

## Interface
- data_width, 8: signed width of each real or imaginary sample.
- no_in_out, 32: points per frame. Fixed at 32; other values are unsupported.
- tw_width, 8: signed twiddle width. The scale is 2^(tw_width-2), so 1.0 = 64.
- clk  in  1  clock; every register updates on its rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- in_valid  in  1  input frame present.
- in_ready  out  1  block can accept a frame. Equals (state == IDLE).
- input_data_real, input_data_imag  in  no_in_out*data_width  packed frame; point k sits at [(k+1)*data_width-1 : k*data_width].
- out_valid  out  1  result frame held on the outputs.
- out_ready  in  1  downstream accepts the result.
- output_data_real, output_data_imag  out  no_in_out*data_width  packed result frame, same packing as the input.

## Operation
- Pairs: pair i (i = 0..15) takes a = point 2i and b = point 2i+1, and writes back to out[2i] and out[2i+1].
- Twiddle: pair i uses W = W32^e with e = 2*(i mod 8), where W32^e = cos(2πe/32) − j·sin(2πe/32).
- Internal constant table, indexed by e/2 = 0..7, listed as (cos, sin) at scale 64: (64,0), (59,24), (45,45), (24,59), (0,64), (−24,59), (−45,45), (−59,24).
- Product t = b·W:
  - tr = br·wr − bi·wi, and ti = br·wi + bi·wr, where wr = cos and wi = −sin.
  - Computed at full width (data_width + tw_width + 1 bits), then arithmetic right shift by tw_width−2 (floor).
- Results: out_a = a + t and out_b = a − t, each component computed at data_width+2 bits and saturated to [−2^(data_width−1), 2^(data_width−1)−1].
- States:
  - IDLE: in_ready = 1. When in_valid is high at an edge, latch both input buses into the frame register, set cnt = 0, go to PROC.
  - PROC: at each edge, lanes 0..3 compute pairs 4·cnt .. 4·cnt+3 and write them into the output registers, then cnt increments. The edge where cnt = 3 moves to DONE.
  - DONE: out_valid = 1. When out_ready is high at an edge, go to IDLE. Otherwise hold.
- The output data registers change only in PROC. They are stable for the whole time out_valid is high, and they keep the last frame after the handshake.
- in_valid is ignored outside IDLE. The input buses are sampled only at the accept edge.

## Timing
- Reset (rst_n low, async):
  - state = IDLE, cnt = 0, out_valid = 0.
  - output_data_real and output_data_imag = 0.
  - Frame register = 0.
  - in_ready = 1 while in reset, but nothing is captured until rst_n is high at an edge.
- Latency: accept at edge T; out_valid rises after edge T+4.
- Minimum frame period is 6 cycles: accept at T, compute at T+1..T+4, handshake at T+5, next accept at T+6.
- Backpressure: with out_ready low, DONE holds indefinitely and in_ready stays 0.
- out_ready high outside DONE has no effect.
- Reset asserted mid-PROC or mid-DONE aborts the frame immediately. Everything returns to its reset value and the partial result is discarded.
- cnt wraps only through the state transition and is never left at 4.

## Test plan
- Reset then idle: after reset, in_ready = 1, out_valid = 0, all outputs 0. Holding in_valid = 0 for 10 cycles causes no change.
- DC frame: all even points = 10+0j, all odd points = 0. Accept at T → out_valid after T+4, every output = 10+0j. Assert out_ready, then in_ready returns one cycle later.
- Twiddle check: pair 4 (e = 8, W = −j) with a = 0, b = 32+0j → out[8] = 0−32j and out[9] = 0+32j. Pair 1 (e = 2) with a = 0, b = 64+0j → out[2] = 59−24j and out[3] = −59+24j.
- Saturation: pair 0 (W = 1) with a = 100, b = 100 → out[0] = 127, out[1] = 0. Pair 0 with a = −100, b = 100 → out[0] = 0, out[1] = −128.
- Backpressure and back-to-back: hold out_ready = 0 for 20 cycles in DONE → outputs stable, in_ready = 0, a second in_valid is not taken. Release out_ready → the second frame is accepted at the next edge, and its result matches the reference model.
- Reset mid-operation: drop rst_n after edge T+2 of a frame → immediately out_valid = 0, outputs 0, state IDLE. A new frame after release produces the correct result in 4 cycles.

Source files
------------

// File: rtl/fft_stage4_butterfly.sv
// Stage-4 radix-2 butterfly of the 32-point FFT: four time-multiplexed lanes
// process the 16 adjacent-pair butterflies over four cycles, with valid/ready on both sides.
module fft_stage4_butterfly #(
  parameter int data_width = 8,
  parameter int no_in_out  = 32,
  parameter int tw_width   = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [no_in_out*data_width-1:0] input_data_real,
  input  logic [no_in_out*data_width-1:0] input_data_imag,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [no_in_out*data_width-1:0] output_data_real,
  output logic [no_in_out*data_width-1:0] output_data_imag
);

  localparam int pw    = data_width + tw_width + 1;
  localparam int sw    = data_width + 2;
  localparam int lanes = 4;
  localparam logic signed [sw-1:0] sat_max = sw'((1 <<< (data_width - 1)) - 1);
  localparam logic signed [sw-1:0] sat_min = sw'(-(1 <<< (data_width - 1)));

  typedef enum logic [1:0] {
    s_idle = 2'd0,
    s_proc = 2'd1,
    s_done = 2'd2
  } state_t;

  state_t     state_r, state_s;
  logic [1:0] cnt_r, cnt_s;

  logic signed [data_width-1:0] fr_re_r  [no_in_out];
  logic signed [data_width-1:0] fr_im_r  [no_in_out];
  logic signed [data_width-1:0] out_re_r [no_in_out];
  logic signed [data_width-1:0] out_im_r [no_in_out];

  logic        [3:0]            pair_s    [lanes];
  logic signed [data_width-1:0] a_re_s    [lanes];
  logic signed [data_width-1:0] a_im_s    [lanes];
  logic signed [data_width-1:0] b_re_s    [lanes];
  logic signed [data_width-1:0] b_im_s    [lanes];
  logic signed [tw_width-1:0]   c_s       [lanes];
  logic signed [tw_width-1:0]   s_s       [lanes];
  logic signed [pw-1:0]         tr_full_s [lanes];
  logic signed [pw-1:0]         ti_full_s [lanes];
  logic signed [sw-1:0]         tr_s      [lanes];
  logic signed [sw-1:0]         ti_s      [lanes];
  logic signed [data_width-1:0] oa_re_s   [lanes];
  logic signed [data_width-1:0] oa_im_s   [lanes];
  logic signed [data_width-1:0] ob_re_s   [lanes];
  logic signed [data_width-1:0] ob_im_s   [lanes];

  // Twiddle table (scale 64) indexed by e/2; W = cos - j*sin
  function automatic logic signed [tw_width-1:0] tw_cos(input logic [2:0] idx);
    logic signed [tw_width-1:0] v;
    case (idx)
      3'd0:    v = tw_width'(64);
      3'd1:    v = tw_width'(59);
      3'd2:    v = tw_width'(45);
      3'd3:    v = tw_width'(24);
      3'd4:    v = tw_width'(0);
      3'd5:    v = tw_width'(-24);
      3'd6:    v = tw_width'(-45);
      3'd7:    v = tw_width'(-59);
      default: v = tw_width'(64);
    endcase
    return v;
  endfunction

  function automatic logic signed [tw_width-1:0] tw_sin(input logic [2:0] idx);
    logic signed [tw_width-1:0] v;
    case (idx)
      3'd0:    v = tw_width'(0);
      3'd1:    v = tw_width'(24);
      3'd2:    v = tw_width'(45);
      3'd3:    v = tw_width'(59);
      3'd4:    v = tw_width'(64);
      3'd5:    v = tw_width'(59);
      3'd6:    v = tw_width'(45);
      3'd7:    v = tw_width'(24);
      default: v = tw_width'(0);
    endcase
    return v;
  endfunction

  function automatic logic signed [data_width-1:0] sat(input logic signed [sw-1:0] v);
    logic signed [data_width-1:0] r;
    if (v > sat_max) begin
      r = sat_max[data_width-1:0];
    end else if (v < sat_min) begin
      r = sat_min[data_width-1:0];
    end else begin
      r = v[data_width-1:0];
    end
    return r;
  endfunction

  assign in_ready  = (state_r == s_idle);
  assign out_valid = (state_r == s_done);

  // State and lane counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= s_idle;
      cnt_r   <= 2'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state logic; cnt wraps 3->0 together with the move to DONE
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      s_idle: begin
        if (in_valid) begin
          state_s = s_proc;
          cnt_s   = 2'd0;
        end else begin
          state_s = s_idle;
        end
      end
      s_proc: begin
        cnt_s = cnt_r + 2'd1;
        if (cnt_r == 2'd3) begin
          state_s = s_done;
        end else begin
          state_s = s_proc;
        end
      end
      s_done: begin
        if (out_ready) begin
          state_s = s_idle;
        end else begin
          state_s = s_done;
        end
      end
      default: begin
        state_s = s_idle;
        cnt_s   = 2'd0;
      end
    endcase
  end

  // Four butterfly lanes; lane l handles pair 4*cnt+l, twiddle index is pair mod 8
  always_comb begin
    for (int l = 0; l < lanes; l++) begin
      pair_s[l]    = {cnt_r, 2'(l)};
      a_re_s[l]    = fr_re_r[{pair_s[l], 1'b0}];
      a_im_s[l]    = fr_im_r[{pair_s[l], 1'b0}];
      b_re_s[l]    = fr_re_r[{pair_s[l], 1'b1}];
      b_im_s[l]    = fr_im_r[{pair_s[l], 1'b1}];
      c_s[l]       = tw_cos(pair_s[l][2:0]);
      s_s[l]       = tw_sin(pair_s[l][2:0]);
      // wi = -sin folded into the signs below
      tr_full_s[l] = pw'(b_re_s[l]) * pw'(c_s[l]) + pw'(b_im_s[l]) * pw'(s_s[l]);
      ti_full_s[l] = pw'(b_im_s[l]) * pw'(c_s[l]) - pw'(b_re_s[l]) * pw'(s_s[l]);
      tr_s[l]      = sw'(tr_full_s[l] >>> (tw_width - 2));
      ti_s[l]      = sw'(ti_full_s[l] >>> (tw_width - 2));
      oa_re_s[l]   = sat(sw'(a_re_s[l]) + tr_s[l]);
      oa_im_s[l]   = sat(sw'(a_im_s[l]) + ti_s[l]);
      ob_re_s[l]   = sat(sw'(a_re_s[l]) - tr_s[l]);
      ob_im_s[l]   = sat(sw'(a_im_s[l]) - ti_s[l]);
    end
  end

  // Frame register: captured only at the accept edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < no_in_out; k++) begin
        fr_re_r[k] <= '0;
        fr_im_r[k] <= '0;
      end
    end else if ((state_r == s_idle) && in_valid) begin
      for (int k = 0; k < no_in_out; k++) begin
        fr_re_r[k] <= input_data_real[k*data_width +: data_width];
        fr_im_r[k] <= input_data_imag[k*data_width +: data_width];
      end
    end
  end

  // Result registers: written only during PROC, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < no_in_out; k++) begin
        out_re_r[k] <= '0;
        out_im_r[k] <= '0;
      end
    end else if (state_r == s_proc) begin
      for (int l = 0; l < lanes; l++) begin
        out_re_r[{pair_s[l], 1'b0}] <= oa_re_s[l];
        out_im_r[{pair_s[l], 1'b0}] <= oa_im_s[l];
        out_re_r[{pair_s[l], 1'b1}] <= ob_re_s[l];
        out_im_r[{pair_s[l], 1'b1}] <= ob_im_s[l];
      end
    end
  end

  for (genvar k = 0; k < no_in_out; k++) begin : g_pack
    assign output_data_real[k*data_width +: data_width] = out_re_r[k];
    assign output_data_imag[k*data_width +: data_width] = out_im_r[k];
  end

endmodule

// File: tb/tb_fft_stage4_butterfly.sv
// Directed bench for fft_stage4_butterfly: hand-computed pair vectors, an integer
// reference model for full frames, plus reset, backpressure and abort sequences.
module tb_fft_stage4_butterfly;
  localparam int dw = 8;
  localparam int n  = 32;

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [n*dw-1:0] input_data_real = '0, input_data_imag = '0;
  logic [n*dw-1:0] output_data_real, output_data_imag;

  int errors = 0, checks = 0;
  int in_re[n], in_im[n], exp_re[n], exp_im[n];
  int cos_t[8] = '{64, 59, 45, 24, 0, -24, -45, -59};
  int sin_t[8] = '{0, 24, 45, 59, 64, 59, 45, 24};

  typedef struct {
    int pair;
    int ar, ai, br, bi;
    int oar, oai, obr, obi;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  fft_stage4_butterfly #(.data_width(8), .no_in_out(32), .tw_width(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .input_data_real(input_data_real), .input_data_imag(input_data_imag),
    .out_valid(out_valid), .out_ready(out_ready),
    .output_data_real(output_data_real), .output_data_imag(output_data_imag)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int out_re(input int k);
    logic signed [dw-1:0] v;
    v = output_data_real[k*dw +: dw];
    return int'(v);
  endfunction

  function automatic int out_im(input int k);
    logic signed [dw-1:0] v;
    v = output_data_imag[k*dw +: dw];
    return int'(v);
  endfunction

  function automatic int fdiv64(input int x);
    int q;
    q = x / 64;
    if ((x % 64) != 0 && x < 0) q = q - 1;
    return q;
  endfunction

  function automatic int clamp(input int x);
    if (x > 127) return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  task automatic run_model();
    for (int i = 0; i < 16; i++) begin
      int wr, wi, tr, ti, ar, ai, br, bi;
      wr = cos_t[i % 8];
      wi = -sin_t[i % 8];
      ar = in_re[2*i];   ai = in_im[2*i];
      br = in_re[2*i+1]; bi = in_im[2*i+1];
      tr = fdiv64(br * wr - bi * wi);
      ti = fdiv64(br * wi + bi * wr);
      exp_re[2*i]   = clamp(ar + tr);
      exp_im[2*i]   = clamp(ai + ti);
      exp_re[2*i+1] = clamp(ar - tr);
      exp_im[2*i+1] = clamp(ai - ti);
    end
  endtask

  task automatic load_bus();
    for (int k = 0; k < n; k++) begin
      input_data_real[k*dw +: dw] = dw'(in_re[k]);
      input_data_imag[k*dw +: dw] = dw'(in_im[k]);
    end
  endtask

  task automatic clear_frame();
    for (int k = 0; k < n; k++) begin
      in_re[k] = 0;
      in_im[k] = 0;
    end
  endtask

  task automatic random_frame();
    for (int k = 0; k < n; k++) begin
      in_re[k] = int'($urandom_range(0, 255)) - 128;
      in_im[k] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  function automatic bit frame_ok();
    for (int k = 0; k < n; k++) begin
      if (out_re(k) != exp_re[k] || out_im(k) != exp_im[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check_frame(input string tag);
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s re[%0d]", tag, k), out_re(k), exp_re[k]);
      check($sformatf("%s im[%0d]", tag, k), out_im(k), exp_im[k]);
    end
  endtask

  // Called at the negedge after the accept edge; counts negedges until out_valid.
  task automatic wait_done(input string tag);
    int c;
    c = 0;
    while (!out_valid && c < 20) begin
      @(negedge clk);
      c++;
    end
    check({tag, " latency"}, c, 4);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " in_ready after handshake"}, int'(in_ready), 1);
    check({tag, " out_valid after handshake"}, int'(out_valid), 0);
  endtask

  task automatic do_frame(input string tag);
    run_model();
    @(negedge clk);
    load_bus();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, " in_ready busy"}, int'(in_ready), 0);
    wait_done(tag);
    check_frame(tag);
    handshake(tag);
  endtask

  initial begin
    vecs[0] = '{4,    0,   0,   32,   0,    0, -32,    0,   32};
    vecs[1] = '{1,    0,   0,   64,   0,   59, -24,  -59,   24};
    vecs[2] = '{0,  100,   0,  100,   0,  127,   0,    0,    0};
    vecs[3] = '{0, -100,   0,  100,   0,    0,   0, -128,    0};
    vecs[4] = '{10,  10,   5,  -64,  32,  -13,  72,   33,  -62};
    vecs[5] = '{15,   0,   0,    0, -128, -48, 118,   48, -118};
    vecs[6] = '{13, -128, 127, 127, 127,  -59, -38, -128,  127};
    vecs[7] = '{3,    1,  -1,   -1,  -1,   -1,  -1,    3,   -1};

    // Reset state, then idle for 10 cycles
    #2;
    check("reset in_ready", int'(in_ready), 1);
    check("reset out_valid", int'(out_valid), 0);
    check("reset outputs zero", int'(output_data_real == '0 && output_data_imag == '0), 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("idle cycle %0d", i),
            int'(in_ready == 1'b1 && out_valid == 1'b0 &&
                 output_data_real == '0 && output_data_imag == '0), 1);
    end

    // DC frame
    clear_frame();
    for (int k = 0; k < n; k += 2) in_re[k] = 10;
    do_frame("dc");
    for (int k = 0; k < n; k++) begin
      check($sformatf("dc hand re[%0d]", k), out_re(k), 10);
      check($sformatf("dc hand im[%0d]", k), out_im(k), 0);
    end

    // Table of hand-computed single-pair vectors
    foreach (vecs[v]) begin
      clear_frame();
      in_re[2*vecs[v].pair]   = vecs[v].ar;
      in_im[2*vecs[v].pair]   = vecs[v].ai;
      in_re[2*vecs[v].pair+1] = vecs[v].br;
      in_im[2*vecs[v].pair+1] = vecs[v].bi;
      do_frame($sformatf("vec%0d", v));
      check($sformatf("vec%0d a.re", v), out_re(2*vecs[v].pair),   vecs[v].oar);
      check($sformatf("vec%0d a.im", v), out_im(2*vecs[v].pair),   vecs[v].oai);
      check($sformatf("vec%0d b.re", v), out_re(2*vecs[v].pair+1), vecs[v].obr);
      check($sformatf("vec%0d b.im", v), out_im(2*vecs[v].pair+1), vecs[v].obi);
    end

    // Random full frames against the model
    for (int r = 0; r < 3; r++) begin
      random_frame();
      do_frame($sformatf("rand%0d", r));
    end

    // Backpressure with a second frame waiting
    random_frame();
    run_model();
    @(negedge clk);
    load_bus();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_done("bp first");
    check_frame("bp first");
    random_frame();
    load_bus();
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("bp hold %0d", i),
            int'(out_valid == 1'b1 && in_ready == 1'b0 && frame_ok()), 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp released in_ready", int'(in_ready), 1);
    check("bp outputs kept after handshake", int'(frame_ok()), 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp second accepted", int'(in_ready), 0);
    run_model();
    wait_done("bp second");
    check_frame("bp second");
    handshake("bp second");

    // Reset during PROC aborts the frame
    random_frame();
    @(negedge clk);
    load_bus();
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort out_valid", int'(out_valid), 0);
    check("abort in_ready", int'(in_ready), 1);
    check("abort outputs zero", int'(output_data_real == '0 && output_data_imag == '0), 1);
    @(negedge clk);
    rst_n = 1'b1;
    random_frame();
    do_frame("after abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
